// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, tap mask and checker state encoding.
package lfsr_pkg;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0101_1001;
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} chk_state_t;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: next feedback bit of the 8-bit LFSR, shared by generator and checker.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic              nxt
);
  assign nxt = ^(state & LFSR_TAPS);
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-seeding LFSR stream checker with lock detection and error counting.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_GOOD  = 8,
  parameter int MISS_LIMIT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_i,
  input  logic                 valid_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  localparam int SW = $clog2(LFSR_W);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  chk_state_t state, state_n;
  logic [LFSR_W-1:0] s, s_n;
  logic [SW-1:0] seed_cnt, seed_n;
  logic [GW-1:0] good_cnt, good_n, good_inc;
  logic [MW-1:0] miss_cnt, miss_n, miss_inc;
  logic [ERR_CNT_W-1:0] err_cnt, err_cnt_n;
  logic p, miss, err_n;

  lfsr_step u_step (.state(s), .nxt(p));

  assign miss      = bit_i != p;
  assign good_inc  = good_cnt + GW'(1);
  assign miss_inc  = miss_cnt + MW'(1);
  assign locked_o  = state == LOCKED;
  assign err_cnt_o = err_cnt;

  always_comb begin
    state_n   = state;
    s_n       = s;
    seed_n    = seed_cnt;
    good_n    = good_cnt;
    miss_n    = miss_cnt;
    err_n     = valid_i && state == LOCKED && miss;
    err_cnt_n = clear_i ? '0 : (err_n && !(&err_cnt)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
    if (valid_i) begin
      case (state)
        SEED: begin
          s_n    = {s[LFSR_W-2:0], bit_i};
          seed_n = seed_cnt + SW'(1);
          if (seed_cnt == SW'(LFSR_W - 1)) begin
            seed_n = '0;
            // an all-zero seed is the generator lock-up state, so keep seeding
            if (|s_n) begin
              state_n = VERIFY;
              good_n  = '0;
            end
          end
        end
        VERIFY: begin
          s_n = {s[LFSR_W-2:0], bit_i};
          if (miss) begin
            state_n = SEED;
            seed_n  = '0;
            good_n  = '0;
          end else begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_GOOD)) begin
              state_n = LOCKED;
              good_n  = '0;
              miss_n  = '0;
            end
          end
        end
        default: begin
          // free-run on the prediction so isolated bit errors do not corrupt it
          s_n = {s[LFSR_W-2:0], p};
          if (!miss) miss_n = '0;
          else if (miss_inc == MW'(MISS_LIMIT)) begin
            state_n = SEED;
            seed_n  = '0;
            miss_n  = '0;
          end else miss_n = miss_inc;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= SEED;
      s        <= '0;
      seed_cnt <= '0;
      good_cnt <= '0;
      miss_cnt <= '0;
      err_cnt  <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      seed_cnt <= seed_n;
      good_cnt <= good_n;
      miss_cnt <= miss_n;
      err_cnt  <= err_cnt_n;
      err_o    <= err_n;
    end
  end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion of the 8-bit LFSR generator. It consumes the generator's serial output stream, one bit per step (the newly shifted-in LSB of the generator register). It self-seeds an internal shadow register from that stream, verifies and declares lock, then counts bit errors against its own prediction. It sits at the far end of a link or loopback path and reports pattern integrity.

## Interface
- `LOCK_GOOD`, default 8: consecutive correct predictions required in VERIFY before lock.
- `MISS_LIMIT`, default 4: consecutive mismatches in LOCKED that drop lock.
- `ERR_CNT_W`, default 16: width of the error counter.
- `clk_i`, in, 1: single clock, all state on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `bit_i`, in, 1: received stream bit.
- `valid_i`, in, 1: `bit_i` is a new stream bit this cycle; state advances only when high.
- `clear_i`, in, 1: synchronous clear of `err_cnt_o`.
- `locked_o`, out, 1: high while in LOCKED.
- `err_o`, out, 1: one-cycle pulse per mismatched bit while LOCKED.
- `err_cnt_o`, out, `ERR_CNT_W`: saturating count of LOCKED mismatches.

## Operation
- Shadow register `s[7:0]` mirrors the generator register: shift left, new bit enters `s[0]`.
- Predicted bit is `p = s[6]^s[4]^s[3]^s[0]`, the same taps as the generator.
- States: SEED, VERIFY, LOCKED. Reset state is SEED.
- **SEED:** on each valid bit, shift `bit_i` into `s` and increment `seed_cnt` (0..7).
  - On the 8th bit, go to VERIFY if the resulting `s` is nonzero.
  - If the resulting `s` is all-zero (generator lock-up pattern), restart `seed_cnt` at 0 and stay in SEED.
- **VERIFY:** on each valid bit, compare `bit_i` with `p` and shift `bit_i` into `s`.
  - On a match, increment `good_cnt`; reaching `LOCK_GOOD` goes to LOCKED.
  - On a mismatch, go to SEED with `seed_cnt` and `good_cnt` cleared.
- **LOCKED:** on each valid bit, shift `p` (not `bit_i`) into `s`, so isolated errors do not corrupt prediction.
  - On a mismatch, pulse `err_o`, increment `err_cnt_o` (saturating at all-ones), and increment `miss_cnt`.
  - On a match, clear `miss_cnt`.
  - When `miss_cnt` reaches `MISS_LIMIT`, go to SEED and clear `seed_cnt`. The error on that bit is still counted.
- `err_cnt_o` is not cleared by a loss of lock. Only `rst_i` or `clear_i` clears it.
- `clear_i` coinciding with a counted error: the clear wins and `err_cnt_o` becomes 0. `err_o` still pulses.
- While `valid_i` is low, all state holds and `err_o` is 0.

## Timing
- Reset values: `locked_o`=0, `err_o`=0, `err_cnt_o`=0, `s`=0, all internal counters 0, state SEED.
- `rst_i` asserted mid-operation returns to these values immediately, with no clock needed.
- All outputs are registered.
  - `err_o` and the `err_cnt_o` increment appear the cycle after the edge that samples the erroneous `valid_i` bit.
  - `locked_o` rises at the edge sampling the `LOCK_GOOD`-th correct VERIFY bit, so it is visible from the next cycle.
  - `locked_o` falls at the edge sampling the `MISS_LIMIT`-th consecutive miss.
- Minimum lock latency with defaults is 16 valid bits. No bubbles are required; `valid_i` may be high every cycle.
- There is no backpressure: the checker always accepts.

## Structure
- Shared package `lfsr_pkg`: `LFSR_W = 8`, tap mask `LFSR_TAPS = 8'b0101_1001`, state enum `chk_state_t` {SEED, VERIFY, LOCKED}.
- One sub-module, `lfsr_step`: combinational next-bit from an 8-bit state using `LFSR_TAPS`. The generator will reuse it so both ends share one tap definition.

## Test plan
- **Clean lock:** generator seeded 0x01 drives the stream 1,1,1,0,0,0,1,… with `valid_i` high continuously. Required: `locked_o`=1 after the 16th bit, `err_cnt_o` stays 0 over 1000 bits.
- **Single error:** after lock, flip one bit. Required: exactly one `err_o` pulse, `err_cnt_o`=1, `locked_o` stays 1, and the following bits produce no errors.
- **Loss of lock:** after lock, invert 4 consecutive bits. Required: `err_cnt_o`=4, `locked_o` falls after the 4th; with a clean stream it relocks 16 valid bits later and `err_cnt_o` stays 4.
- **All-zero stream:** drive a constant 0 stream. Required: never leaves SEED, `locked_o` stays 0.
- **VERIFY failure and gapped valid:** corrupt the 12th bit, with `valid_i` toggling 1,0. Required: return to SEED, lock after 16 further clean valid bits, `err_cnt_o`=0.
- **Clear and reset:** `clear_i` coincident with an error gives `err_cnt_o`=0. Asserting `rst_i` asynchronously mid-LOCKED gives all outputs 0 before the next edge.
